// File: rtl/input_debounce.sv
// Switch/pin debouncer: synchronizer chain feeding a four-state qualifier
// that accepts a new level only after STABLE_CYCLES agreeing samples.
module input_debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    PEND_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    PEND_LOW    = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            out_reg, out_next;
  logic            rise_reg, rise_next;
  logic            fall_reg, fall_next;
  logic            busy_reg, busy_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], in};
    end
  end

  assign sync = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= STABLE_LOW;
      cnt_reg   <= '0;
      out_reg   <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
      busy_reg  <= busy_next;
    end
  end

  // cnt holds the number of agreeing samples seen so far; it tops out at CNT_LAST
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      STABLE_LOW: begin
        if (sync) begin
          state_next = PEND_HIGH;
          cnt_next   = CW'(1);
        end else begin
          cnt_next = '0;
        end
      end
      PEND_HIGH: begin
        if (!sync) begin
          state_next = STABLE_LOW;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = STABLE_HIGH;
          cnt_next   = '0;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      STABLE_HIGH: begin
        if (!sync) begin
          state_next = PEND_LOW;
          cnt_next   = CW'(1);
        end else begin
          cnt_next = '0;
        end
      end
      PEND_LOW: begin
        if (sync) begin
          state_next = STABLE_HIGH;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = STABLE_LOW;
          cnt_next   = '0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = STABLE_LOW;
        cnt_next   = '0;
      end
    endcase
    // Level and busy are pure functions of the state, registered alongside it
    out_next  = (state_next == STABLE_HIGH) || (state_next == PEND_LOW);
    busy_next = (state_next == PEND_HIGH)   || (state_next == PEND_LOW);
  end

  assign out  = out_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: cycle table on the default instance plus
// latency/pulse sweeps over three parameterizations.
module tb_input_debounce;

  logic clk = 1'b0;
  logic reset_s = 1'b1;
  logic in_s = 1'b0;

  logic o[3], r[3], f[3], b[3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  input_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut0 (
    .clk(clk), .reset(reset_s), .in(in_s), .out(o[0]), .rise(r[0]), .fall(f[0]), .busy(b[0]));
  input_debounce #(.SYNC_STAGES(3), .STABLE_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset_s), .in(in_s), .out(o[1]), .rise(r[1]), .fall(f[1]), .busy(b[1]));
  input_debounce #(.SYNC_STAGES(3), .STABLE_CYCLES(16)) dut2 (
    .clk(clk), .reset(reset_s), .in(in_s), .out(o[2]), .rise(r[2]), .fall(f[2]), .busy(b[2]));

  int ss_tab[3] = '{2, 3, 3};
  int sc_tab[3] = '{4, 2, 16};

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst;
    logic din;
    logic out;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic din, input logic eo,
                              input logic er, input logic ef, input logic eb);
    vec_t v;
    v.rst = rst; v.din = din; v.out = eo; v.rise = er; v.fall = ef; v.busy = eb;
    vecs.push_back(v);
  endfunction

  // Pulse sanity on the default instance every cycle
  logic r_prev = 1'b0, f_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    chk("rise_fall_exclusive", int'(r[0] & f[0]), 0);
    chk("pulse_single_cycle", int'((r[0] & r_prev) | (f[0] & f_prev)), 0);
    r_prev = r[0];
    f_prev = f[0];
  end

  // Drive a new level and watch all three instances for up to 40 edges.
  task automatic measure(input logic lvl);
    int lat[3], pedge[3], pulses[3], wrong[3], trans[3], bcyc[3];
    logic prev[3];
    for (int d = 0; d < 3; d++) begin
      lat[d] = 0; pedge[d] = 0; pulses[d] = 0; wrong[d] = 0; trans[d] = 0; bcyc[d] = 0;
      prev[d] = o[d];
    end
    @(negedge clk);
    in_s = lvl;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (o[d] != prev[d]) begin
          trans[d]++;
          if (lat[d] == 0) lat[d] = k;
          prev[d] = o[d];
        end
        if ((lvl ? r[d] : f[d]) == 1'b1) begin
          pulses[d]++;
          if (pedge[d] == 0) pedge[d] = k;
        end
        if ((lvl ? f[d] : r[d]) == 1'b1) wrong[d]++;
        if (b[d]) bcyc[d]++;
      end
    end
    for (int d = 0; d < 3; d++) begin
      $display("sweep dut%0d level=%0d latency=%0d pulse_edge=%0d busy_cycles=%0d",
               d, lvl, lat[d], pedge[d], bcyc[d]);
      chk($sformatf("dut%0d_latency_lvl%0d", d, lvl), lat[d], ss_tab[d] + sc_tab[d]);
      chk($sformatf("dut%0d_pulse_edge_lvl%0d", d, lvl), pedge[d], ss_tab[d] + sc_tab[d]);
      chk($sformatf("dut%0d_pulse_count_lvl%0d", d, lvl), pulses[d], 1);
      chk($sformatf("dut%0d_wrong_pulse_lvl%0d", d, lvl), wrong[d], 0);
      chk($sformatf("dut%0d_downstream_transitions_lvl%0d", d, lvl), trans[d], 1);
      chk($sformatf("dut%0d_busy_cycles_lvl%0d", d, lvl), bcyc[d], sc_tab[d] - 1);
      chk($sformatf("dut%0d_final_out_lvl%0d", d, lvl), int'(o[d]), int'(lvl));
    end
  endtask

  initial begin
    // rst, in, out, rise, fall, busy -- one row per rising edge
    add(1,0, 0,0,0,0); add(1,0, 0,0,0,0);
    // clean 0->1 step: first sample at row 2, accepted on edge 6
    add(0,1, 0,0,0,0); add(0,1, 0,0,0,0); add(0,1, 0,0,0,1); add(0,1, 0,0,0,1);
    add(0,1, 0,0,0,1); add(0,1, 1,1,0,0); add(0,1, 1,0,0,0); add(0,1, 1,0,0,0);
    // 3-cycle low glitch from STABLE_HIGH
    add(0,0, 1,0,0,0); add(0,0, 1,0,0,0); add(0,0, 1,0,0,1); add(0,1, 1,0,0,1);
    add(0,1, 1,0,0,1); add(0,1, 1,0,0,0); add(0,1, 1,0,0,0);
    // clean 1->0 step
    add(0,0, 1,0,0,0); add(0,0, 1,0,0,0); add(0,0, 1,0,0,1); add(0,0, 1,0,0,1);
    add(0,0, 1,0,0,1); add(0,0, 0,0,1,0); add(0,0, 0,0,0,0); add(0,0, 0,0,0,0);
    // bounce 1,0,1,0 then held 1
    add(0,1, 0,0,0,0); add(0,0, 0,0,0,0); add(0,1, 0,0,0,1); add(0,0, 0,0,0,0);
    add(0,1, 0,0,0,1); add(0,1, 0,0,0,0); add(0,1, 0,0,0,1); add(0,1, 0,0,0,1);
    add(0,1, 0,0,0,1); add(0,1, 1,1,0,0); add(0,1, 1,0,0,0);
    // reset while qualifying (cnt=2), then held with in high
    add(0,0, 1,0,0,0); add(0,0, 1,0,0,0); add(0,0, 1,0,0,1); add(0,0, 1,0,0,1);
    add(1,0, 0,0,0,0); add(1,1, 0,0,0,0); add(1,1, 0,0,0,0); add(1,1, 0,0,0,0);
    // release with in already high
    add(0,1, 0,0,0,0); add(0,1, 0,0,0,0); add(0,1, 0,0,0,1); add(0,1, 0,0,0,1);
    add(0,1, 0,0,0,1); add(0,1, 1,1,0,0); add(0,1, 1,0,0,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset_s = vecs[i].rst;
      in_s    = vecs[i].din;
      @(posedge clk);
      #1;
      $display("row %0d rst=%0d in=%0d -> out=%0d rise=%0d fall=%0d busy=%0d",
               i, vecs[i].rst, vecs[i].din, o[0], r[0], f[0], b[0]);
      chk($sformatf("row%0d_out", i),  int'(o[0]), int'(vecs[i].out));
      chk($sformatf("row%0d_rise", i), int'(r[0]), int'(vecs[i].rise));
      chk($sformatf("row%0d_fall", i), int'(f[0]), int'(vecs[i].fall));
      chk($sformatf("row%0d_busy", i), int'(b[0]), int'(vecs[i].busy));
    end

    // parameter sweep: reset everything low, then a rising and a falling step
    @(negedge clk);
    reset_s = 1'b1;
    in_s    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d_reset_out", d),  int'(o[d]), 0);
      chk($sformatf("dut%0d_reset_busy", d), int'(b[d]), 0);
    end
    @(negedge clk);
    reset_s = 1'b0;
    repeat (4) @(posedge clk);
    measure(1'b1);
    measure(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
